// File: rtl/bytebeat_sample_scheduler_pkg.sv
// rtl/bytebeat_sample_scheduler_pkg.sv - shared types and constants for the bytebeat sample scheduler
// Contents: sched_state_e (WAIT, FETCH), PCM_W (PCM sample width), PCM_MID (silence midpoint).
package bytebeat_sched_pkg;

    localparam int          PCM_W   = 8;
    localparam logic [7:0]  PCM_MID = 8'h80;

    typedef enum logic {
        WAIT  = 1'b0,
        FETCH = 1'b1
    } sched_state_e;

endpackage

// File: rtl/bytebeat_sample_scheduler_if.sv
// rtl/bytebeat_sample_scheduler_if.sv - voice stream and sample output bundle for the scheduler
// Signals: voice_data/voice_vld/voice_rdy (per-voice PCM streams), voice_sel, mute,
//          sample/sample_vld (held PCM output), underrun_cnt.
// Modports: master (generator/consumer side), slave (scheduler side).
interface bytebeat_sample_scheduler_if #(
    parameter int NUM_VOICES = 8
);
    import bytebeat_sched_pkg::*;

    logic [PCM_W*NUM_VOICES-1:0] voice_data;
    logic [NUM_VOICES-1:0]       voice_vld;
    logic [NUM_VOICES-1:0]       voice_rdy;
    logic [2:0]                  voice_sel;
    logic                        mute;
    logic [PCM_W-1:0]            sample;
    logic                        sample_vld;
    logic [7:0]                  underrun_cnt;

    modport master (
        output voice_data, voice_vld, voice_sel, mute,
        input  voice_rdy, sample, sample_vld, underrun_cnt
    );

    modport slave (
        input  voice_data, voice_vld, voice_sel, mute,
        output voice_rdy, sample, sample_vld, underrun_cnt
    );

endinterface

// File: rtl/bytebeat_sample_scheduler_tick_gen.sv
// rtl/bytebeat_sample_scheduler_tick_gen.sv - sample-period divider producing a one-cycle tick
// Ports: clk (clock), rst_n (sync active-low reset), tick (high one cycle in every CLK_DIV).
// The first tick is high in the CLK_DIV-th cycle after reset release.
module sample_tick_gen #(
    parameter int CLK_DIV = 6250
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] div_q, div_d;

    assign tick  = (div_q == DIV_LAST);
    assign div_d = tick ? 16'd0 : div_q + 16'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= 16'd0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/bytebeat_sample_scheduler.sv
// rtl/bytebeat_sample_scheduler.sv - picks one bytebeat voice per sample period and holds its PCM sample
// Ports: clk, rst_n (sync active-low), bus (bytebeat_sample_scheduler_if.slave: voice streams,
//        voice_sel, mute, sample, sample_vld, underrun_cnt).
// Build option: SCHED_UNDERRUN_CNT_EN enables the saturating underrun counter; otherwise it reads 0.
module bytebeat_sample_scheduler
    import bytebeat_sched_pkg::*;
#(
    parameter int CLK_DIV    = 6250,
    parameter int NUM_VOICES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    bytebeat_sample_scheduler_if.slave    bus
);

    logic                  tick;
    sched_state_e          state_q, state_d;
    logic [2:0]            active_q, active_d;
    logic [PCM_W-1:0]      sample_q, sample_d;
    logic                  sample_vld_q, sample_vld_d;
    logic [NUM_VOICES-1:0] rdy;
    logic [PCM_W-1:0]      act_data;
    logic [2:0]            sel_mapped;
    logic                  hs;

    sample_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Out-of-range selections fall back to voice 0.
    assign sel_mapped = ({29'd0, bus.voice_sel} < NUM_VOICES) ? bus.voice_sel : 3'd0;

    // rdy is decoded from registered state, so it drops on the same edge a reset lands.
    assign rdy = (state_q == FETCH) ? (NUM_VOICES'(1) << active_q) : '0;
    assign hs  = |(rdy & bus.voice_vld);

    always_comb begin
        act_data = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (3'(i) == active_q) begin
                act_data = bus.voice_data[PCM_W*i +: PCM_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        sample_d     = sample_q;
        sample_vld_d = 1'b0;
        case (state_q)
            WAIT: begin
                if (tick) begin
                    state_d  = FETCH;
                    active_d = sel_mapped;
                end
            end
            FETCH: begin
                if (hs) begin
                    sample_d     = bus.mute ? PCM_MID : act_data;
                    sample_vld_d = 1'b1;
                end
                // A tick in FETCH starts the next period without leaving FETCH,
                // whether or not this period's sample arrived.
                if (tick) begin
                    active_d = sel_mapped;
                end else if (hs) begin
                    state_d = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= WAIT;
            active_q     <= 3'd0;
            sample_q     <= PCM_MID;
            sample_vld_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
        end
    end

`ifdef SCHED_UNDERRUN_CNT_EN
    logic       underrun;
    logic [7:0] ucnt_q, ucnt_d;

    assign underrun = (state_q == FETCH) && tick && !hs;
    assign ucnt_d   = (underrun && (ucnt_q != 8'hFF)) ? ucnt_q + 8'd1 : ucnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ucnt_q <= 8'd0;
        end else begin
            ucnt_q <= ucnt_d;
        end
    end

    assign bus.underrun_cnt = ucnt_q;
`else
    assign bus.underrun_cnt = 8'd0;
`endif

    assign bus.voice_rdy  = rdy;
    assign bus.sample     = sample_q;
    assign bus.sample_vld = sample_vld_q;

endmodule

// File: tb/tb_bytebeat_sample_scheduler.sv
// tb/tb_bytebeat_sample_scheduler.sv - directed self-checking bench for bytebeat_sample_scheduler
module tb_bytebeat_sample_scheduler;

    localparam int CLK_DIV    = 8;
    localparam int NUM_VOICES = 6;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    bytebeat_sample_scheduler_if #(.NUM_VOICES(NUM_VOICES)) bus ();

    bytebeat_sample_scheduler #(
        .CLK_DIV    (CLK_DIV),
        .NUM_VOICES (NUM_VOICES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef SCHED_UNDERRUN_CNT_EN
        return (n > 255) ? 32'd255 : 32'(n);
`else
        return (n > 255) ? 32'd0 : 32'd0 * 32'(n);
`endif
    endfunction

    initial begin
        rst_n          = 1'b0;
        bus.voice_data = '0;
        bus.voice_vld  = '0;
        bus.voice_sel  = 3'd2;
        bus.mute       = 1'b0;
        bus.voice_data[16 +: 8] = 8'h5A;
        bus.voice_vld[2]        = 1'b1;

        adv(2);
        chk("rst_sample",     32'(bus.sample),       32'h80);
        chk("rst_sample_vld", 32'(bus.sample_vld),   32'h0);
        chk("rst_rdy",        32'(bus.voice_rdy),    32'h0);
        chk("rst_ucnt",       32'(bus.underrun_cnt), 32'h0);
        rst_n = 1'b1;

        // Basic fetch: tick in cycle 8, rdy in cycle 9, sample in cycle 10.
        adv(7);
        chk("pre_tick_rdy",   32'(bus.voice_rdy),    32'h00);
        adv(1);
        chk("e8_rdy2",        32'(bus.voice_rdy),    32'h04);
        chk("e8_sample_hold", 32'(bus.sample),       32'h80);
        chk("e8_svld0",       32'(bus.sample_vld),   32'h0);
        adv(1);
        chk("e9_sample",      32'(bus.sample),       32'h5A);
        chk("e9_svld",        32'(bus.sample_vld),   32'h1);
        chk("e9_rdy_off",     32'(bus.voice_rdy),    32'h00);
        chk("e9_ucnt",        32'(bus.underrun_cnt), 32'h0);
        adv(1);
        chk("e10_svld_pulse", 32'(bus.sample_vld),   32'h0);
        bus.voice_vld = '0;

        // Starved voice 2: rdy stays up, underruns accumulate, sample holds.
        adv(7);
        chk("e17_rdy2",       32'(bus.voice_rdy),    32'h04);
        adv(7);
        chk("e24_rdy2",       32'(bus.voice_rdy),    32'h04);
        chk("e24_ucnt",       32'(bus.underrun_cnt), exp_cnt(1));
        chk("e24_svld0",      32'(bus.sample_vld),   32'h0);
        adv(8);
        chk("e32_ucnt",       32'(bus.underrun_cnt), exp_cnt(2));
        chk("e32_sample",     32'(bus.sample),       32'h5A);

        // voice_sel 2->5 mid-period only takes effect at the next tick.
        adv(3);
        bus.voice_sel = 3'd5;
        bus.voice_data[40 +: 8] = 8'hC3;
        bus.voice_vld[5]        = 1'b1;
        adv(1);
        chk("e36_rdy_still2", 32'(bus.voice_rdy),    32'h04);
        chk("e36_no_capture", 32'(bus.sample),       32'h5A);
        adv(4);
        chk("e40_rdy5",       32'(bus.voice_rdy),    32'h20);
        chk("e40_ucnt",       32'(bus.underrun_cnt), exp_cnt(3));
        bus.voice_data[16 +: 8] = 8'h11;
        bus.voice_vld[2]        = 1'b1;
        adv(1);
        chk("e41_sample_v5",  32'(bus.sample),       32'hC3);
        chk("e41_svld",       32'(bus.sample_vld),   32'h1);
        chk("e41_rdy_off",    32'(bus.voice_rdy),    32'h00);

        // Mute with out-of-range select (7 -> voice 0).
        bus.voice_vld           = '0;
        bus.voice_sel           = 3'd7;
        bus.voice_data[0 +: 8]  = 8'hFF;
        bus.voice_vld[0]        = 1'b1;
        bus.mute                = 1'b1;
        adv(7);
        chk("sel7_maps_v0",   32'(bus.voice_rdy),    32'h01);
        adv(1);
        chk("mute_sample",    32'(bus.sample),       32'h80);
        chk("mute_svld",      32'(bus.sample_vld),   32'h1);
        chk("mute_drained",   32'(bus.voice_rdy),    32'h00);

        // vld arriving exactly on the tick edge of a pending fetch.
        bus.mute                = 1'b0;
        bus.voice_vld           = '0;
        bus.voice_sel           = 3'd3;
        bus.voice_data[24 +: 8] = 8'hA5;
        adv(7);
        chk("e56_rdy3",       32'(bus.voice_rdy),    32'h08);
        adv(7);
        chk("e63_rdy3",       32'(bus.voice_rdy),    32'h08);
        bus.voice_vld[3] = 1'b1;
        bus.voice_sel    = 3'd1;
        adv(1);
        chk("tie_sample",     32'(bus.sample),       32'hA5);
        chk("tie_svld",       32'(bus.sample_vld),   32'h1);
        chk("tie_rdy_next",   32'(bus.voice_rdy),    32'h02);
        chk("tie_ucnt",       32'(bus.underrun_cnt), exp_cnt(3));
        bus.voice_vld = '0;

        // 300 consecutive underruns saturate the counter.
        adv(CLK_DIV * 300);
        chk("sat_ucnt",       32'(bus.underrun_cnt), exp_cnt(303));
        chk("sat_sample",     32'(bus.sample),       32'hA5);
        chk("sat_rdy1",       32'(bus.voice_rdy),    32'h02);

        // Reset mid-FETCH with a valid word waiting: aborted without capture.
        adv(3);
        bus.voice_data[8 +: 8] = 8'h77;
        bus.voice_vld[1]       = 1'b1;
        rst_n                  = 1'b0;
        adv(1);
        chk("midrst_sample",  32'(bus.sample),       32'h80);
        chk("midrst_svld",    32'(bus.sample_vld),   32'h0);
        chk("midrst_rdy",     32'(bus.voice_rdy),    32'h00);
        chk("midrst_ucnt",    32'(bus.underrun_cnt), 32'h0);
        rst_n = 1'b1;
        adv(7);
        chk("post_rst_wait",  32'(bus.voice_rdy),    32'h00);
        adv(1);
        chk("post_rst_rdy1",  32'(bus.voice_rdy),    32'h02);
        adv(1);
        chk("post_rst_sample", 32'(bus.sample),      32'h77);
        chk("post_rst_svld",  32'(bus.sample_vld),   32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bytebeat_sample_scheduler.md
BYTEBEAT_SAMPLE_SCHEDULER -- requirements
Module: bytebeat_sample_scheduler

Interface
REQ-001: Parameter CLK_DIV, default 6250, clk cycles per sample period (8 kHz at 50 MHz); legal range 4..65535.
REQ-002: Parameter NUM_VOICES, default 8, number of bytebeat generator streams.
REQ-003: clk  input  1  sole clock; all state SHALL change only on its rising edge.
REQ-004: rst_n  input  1  reset, synchronous, active-low.
REQ-005: voice_data  input  8*NUM_VOICES  packed PCM from generators; voice i occupies bits [8i+7:8i].
REQ-006: voice_vld  input  NUM_VOICES  per-voice sample valid.
REQ-007: voice_rdy  output  NUM_VOICES  per-voice ready; at most one bit high per cycle.
REQ-008: voice_sel  input  3  requested voice index.
REQ-009: mute  input  1  force output to midpoint.
REQ-010: sample  output  8  held PCM sample for the pwm_audio stage.
REQ-011: sample_vld  output  1  one-cycle pulse when sample updates.
REQ-012: underrun_cnt  output  8  saturating count of missed sample periods.

Function
REQ-013: Tick generator SHALL assert a one-cycle tick every CLK_DIV cycles; the first tick occurs CLK_DIV cycles after reset release.
REQ-014: FSM states: WAIT, FETCH; reset state WAIT.
REQ-015: WAIT -> FETCH on tick; voice_sel SHALL be latched into active_voice on that same edge and ignored at all other times.
REQ-016: In FETCH, voice_rdy[active_voice] SHALL be 1 and all other rdy bits 0; in WAIT, all rdy bits 0.
REQ-017: Handshake completes in a cycle where rdy and vld of the active voice are both 1; data SHALL be captured on that edge, and the FSM SHALL return to WAIT.
REQ-018: Latency: rdy rises the cycle after tick; sample and sample_vld update the cycle after the handshake.
REQ-019: When mute=1 at capture, sample SHALL become 8'h80 instead of the captured data; the handshake still completes (the stream is drained).
REQ-020: If the next tick arrives while still in FETCH: underrun; sample SHALL hold its previous value, no sample_vld, underrun_cnt increments by 1 and saturates at 255, voice_sel is re-latched, and the FSM stays in FETCH.
REQ-021: Handshake and tick in the same cycle: handshake SHALL win (sample captured, no underrun), and the FSM SHALL stay in FETCH for the new period with voice_sel latched.
REQ-022: voice_sel >= NUM_VOICES SHALL be treated as voice 0.
REQ-023: A vld on an inactive voice SHALL have no effect.

Reset
REQ-024: With rst_n=0 at a clock edge: sample=8'h80, sample_vld=0, voice_rdy=0, underrun_cnt=0, divider=0, active_voice=0, state=WAIT.
REQ-025: Reset mid-FETCH SHALL abort the fetch without capture; rdy deasserts on the reset edge.

Configuration
REQ-026: Macro SCHED_UNDERRUN_CNT_EN: when defined, the counter behaves per REQ-020.
REQ-027: When SCHED_UNDERRUN_CNT_EN is undefined, underrun_cnt SHALL be constant 0, no counter flops are synthesized, and the sample-hold behaviour on underrun is unchanged.

Structure
REQ-028: Package bytebeat_sched_pkg SHALL hold: the state enum (WAIT, FETCH), PCM_MID=8'h80, and the PCM width constant 8.
REQ-029: Sub-module sample_tick_gen (parameter CLK_DIV; ports clk, rst_n, tick) SHALL implement the divider; everything else is flat in bytebeat_sample_scheduler.

Verification
REQ-030: CLK_DIV=8, voice_sel=2, voice 2 vld=1 with data 8'h5A -> rdy[2] high at cycle 9, sample=8'h5A with sample_vld pulse at cycle 10, underrun_cnt=0.
REQ-031: voice 2 vld held 0 for 3 periods -> sample stays 8'h80, underrun_cnt=2, rdy[2] continuously high from the first tick.
REQ-032: voice_sel changes 2->5 mid-period -> rdy[5] is asserted only from the next tick; voice 2 data is never captured after that tick.
REQ-033: mute=1, voice 0 data 8'hFF valid -> handshake occurs, sample=8'h80, sample_vld pulses.
REQ-034: vld asserted exactly on the tick edge of a pending FETCH -> sample captured, underrun_cnt unchanged, rdy stays high into the next period.
REQ-035: 300 consecutive underruns -> underrun_cnt=255 (0 without SCHED_UNDERRUN_CNT_EN); rst_n pulsed mid-FETCH -> all outputs at reset values on the next edge.
